// File: rtl/bcd_seg7_if.sv
// Signal bundle between a BCD digit source and the 7-segment scanner.
interface bcd_seg7_if #(
    parameter int unsigned NDIG = 4
);
    logic              en;
    logic [4*NDIG-1:0] bcd;
    logic [NDIG-1:0]   dp;
    logic              blank_lz;
    logic [6:0]        seg;
    logic              dp_out;
    logic [NDIG-1:0]   an;
    logic              frame_tick;

    modport master (
        output en, bcd, dp, blank_lz,
        input  seg, dp_out, an, frame_tick
    );

    modport slave (
        input  en, bcd, dp, blank_lz,
        output seg, dp_out, an, frame_tick
    );
endinterface

// File: rtl/bcd_seg7_scanner.sv
// Time-multiplexed 7-segment driver for NDIG packed BCD digits with a per-frame
// input snapshot, leading-zero blanking, invalid-code glyph, inter-digit anode
// blanking and a frame tick. All outputs are registered.
module bcd_seg7_scanner #(
    parameter int unsigned NDIG        = 4,
    parameter int unsigned SCAN_DIV    = 1000,
    parameter int unsigned BLANK_CYC   = 2,
    parameter bit          SEG_ACT_LOW = 1'b1,
    parameter bit          AN_ACT_LOW  = 1'b1
) (
    input logic       clk,
    input logic       rst,
    bcd_seg7_if.slave bus
);
    localparam int unsigned       CNT_W    = $clog2(SCAN_DIV);
    localparam int unsigned       IDX_W    = $clog2(NDIG);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NDIG - 1);
    localparam logic [6:0]        SEG_OFF  = {7{SEG_ACT_LOW}};
    localparam logic              DP_OFF   = SEG_ACT_LOW;
    localparam logic [NDIG-1:0]   AN_OFF   = {NDIG{AN_ACT_LOW}};

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [4*NDIG-1:0] snap_bcd_q, snap_bcd_d;
    logic [NDIG-1:0]   snap_dp_q, snap_dp_d;
    logic              snap_lz_q, snap_lz_d;
    logic [6:0]        seg_q, seg_d;
    logic              dp_q, dp_d;
    logic [NDIG-1:0]   an_q, an_d;
    logic              tick_q, tick_d;

    logic [NDIG-1:0]   zero_above;
    logic [3:0]        cur_digit;
    logic              blanked;
    logic              slot_lit;
    logic [6:0]        seg_act;
    logic              dp_act;
    logic [NDIG-1:0]   an_act;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'h3F;
            4'd1:    seg_decode = 7'h06;
            4'd2:    seg_decode = 7'h5B;
            4'd3:    seg_decode = 7'h4F;
            4'd4:    seg_decode = 7'h66;
            4'd5:    seg_decode = 7'h6D;
            4'd6:    seg_decode = 7'h7D;
            4'd7:    seg_decode = 7'h07;
            4'd8:    seg_decode = 7'h7F;
            4'd9:    seg_decode = 7'h6F;
            default: seg_decode = 7'h40;
        endcase
    endfunction

    // Anodes stay dark for the first BLANK_CYC cycles of every slot.
    if (BLANK_CYC == 0) begin : g_no_blank
        assign slot_lit = 1'b1;
    end else begin : g_blank
        assign slot_lit = (cnt_q >= CNT_W'(BLANK_CYC));
    end

    // Scan position advance and frame-start snapshot capture.
    always_comb begin
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        snap_bcd_d = snap_bcd_q;
        snap_dp_d  = snap_dp_q;
        snap_lz_d  = snap_lz_q;
        if (bus.en) begin
            if (cnt_q == '0 && idx_q == '0) begin
                snap_bcd_d = bus.bcd;
                snap_dp_d  = bus.dp;
                snap_lz_d  = bus.blank_lz;
            end
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // zero_above[i] is set when snapshot digits NDIG-1 down to i are all zero.
    always_comb begin
        logic run;
        run        = 1'b1;
        zero_above = '0;
        for (int unsigned k = 0; k < NDIG; k++) begin
            run = run & (snap_bcd_q[4*(NDIG-1-k) +: 4] == 4'd0);
            zero_above[NDIG-1-k] = run;
        end
    end

    // Next output values from the current scan position and snapshot.
    always_comb begin
        cur_digit = snap_bcd_q[{idx_q, 2'b00} +: 4];
        blanked   = snap_lz_q && (idx_q != '0) && zero_above[idx_q];
        seg_act   = blanked ? 7'h00 : seg_decode(cur_digit);
        dp_act    = blanked ? 1'b0 : snap_dp_q[idx_q];
        an_act    = '0;
        an_act[idx_q] = slot_lit;

        seg_d  = SEG_OFF;
        dp_d   = DP_OFF;
        an_d   = AN_OFF;
        tick_d = 1'b0;
        if (bus.en) begin
            seg_d  = SEG_ACT_LOW ? ~seg_act : seg_act;
            dp_d   = SEG_ACT_LOW ? ~dp_act : dp_act;
            an_d   = AN_ACT_LOW ? ~an_act : an_act;
            tick_d = (cnt_q == CNT_LAST) && (idx_q == IDX_LAST);
        end
    end

    // State and output registers; reset darkens the display immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            snap_bcd_q <= '0;
            snap_dp_q  <= '0;
            snap_lz_q  <= 1'b0;
            seg_q      <= SEG_OFF;
            dp_q       <= DP_OFF;
            an_q       <= AN_OFF;
            tick_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            snap_bcd_q <= snap_bcd_d;
            snap_dp_q  <= snap_dp_d;
            snap_lz_q  <= snap_lz_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            an_q       <= an_d;
            tick_q     <= tick_d;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.dp_out     = dp_q;
    assign bus.an         = an_q;
    assign bus.frame_tick = tick_q;
endmodule
